// File: rtl/pipe_pkg.sv
// Shared types and helpers for the handshaked pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam int OCC_W      = 2;
    localparam int CTRL_MAX_W = 64;

    // Retained bits take the incoming control value, the rest fall back to the reset value.
    function automatic logic [CTRL_MAX_W-1:0] flush_ctrl(
        input logic [CTRL_MAX_W-1:0] in_v,
        input logic [CTRL_MAX_W-1:0] keep,
        input logic [CTRL_MAX_W-1:0] rst_v
    );
        return (in_v & keep) | (rst_v & ~keep);
    endfunction

endpackage

// File: rtl/pipe_stage_hs_entry.sv
// One valid+ctrl+data register slot; flush beats load, load beats drop.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] RST_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [CTRL_W-1:0] flush_val,
    input  logic              load,
    input  logic              drop,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Payload is left untouched on drop so it holds while the slot is invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= RST_CTRL;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= flush_val;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
            data  <= ld_data;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, flush with control-bit retention,
// and an optional 2-entry skid buffer giving a registered in_ready.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                CTRL_W     = 8,
    parameter logic [CTRL_W-1:0] RST_CTRL   = '0,
    parameter logic [CTRL_W-1:0] FLUSH_KEEP = '0,
    parameter bit                SKID       = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occ
);

    logic              accept;
    logic              emit;
    logic [CTRL_W-1:0] flush_val;
    logic              head_load;
    logic              head_drop;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] head_ld_ctrl;
    logic [DATA_W-1:0] head_ld_data;

    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign flush_val = CTRL_W'(flush_ctrl(CTRL_MAX_W'(in_ctrl),
                                          CTRL_MAX_W'(FLUSH_KEEP),
                                          CTRL_MAX_W'(RST_CTRL)));

    // A valid skid entry always refills the head first to keep strict FIFO order.
    assign head_ld_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    assign head_ld_data = skid_valid ? skid_data : in_data;

    pipe_entry #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .RST_CTRL (RST_CTRL)
    ) u_head (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .flush_val (flush_val),
        .load      (head_load),
        .drop      (head_drop),
        .ld_ctrl   (head_ld_ctrl),
        .ld_data   (head_ld_data),
        .valid     (out_valid),
        .ctrl      (out_ctrl),
        .data      (out_data)
    );

    generate
        if (SKID) begin : g_skid
            stage_state_e state;
            logic         in_ready_q;
            logic         skid_load;
            logic         skid_drop;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end else if (flush) begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (accept) state <= ONE;
                        end
                        ONE: begin
                            if (accept && !emit) begin
                                state      <= FULL;
                                in_ready_q <= 1'b0;
                            end else if (!accept && emit) begin
                                state <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (emit) begin
                                state      <= ONE;
                                in_ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state      <= EMPTY;
                            in_ready_q <= 1'b1;
                        end
                    endcase
                end
            end

            always_comb begin
                head_load = 1'b0;
                head_drop = 1'b0;
                skid_load = 1'b0;
                skid_drop = 1'b0;
                case (state)
                    EMPTY: head_load = accept;
                    ONE: begin
                        head_load = accept & emit;
                        head_drop = ~accept & emit;
                        skid_load = accept & ~emit;
                    end
                    FULL: begin
                        head_load = emit;
                        skid_drop = emit;
                    end
                    default: ;
                endcase
            end

            assign in_ready = in_ready_q;
            assign occ      = OCC_W'(state);

            pipe_entry #(
                .DATA_W   (DATA_W),
                .CTRL_W   (CTRL_W),
                .RST_CTRL (RST_CTRL)
            ) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (flush),
                .flush_val (flush_val),
                .load      (skid_load),
                .drop      (skid_drop),
                .ld_ctrl   (in_ctrl),
                .ld_data   (in_data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );
        end else begin : g_single
            assign in_ready   = out_ready | ~out_valid;
            assign head_load  = accept;
            assign head_drop  = emit & ~accept;
            assign occ        = {1'b0, out_valid};
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed-vector and reference-FIFO bench for pipe_stage_hs in skid and single-register builds.
module tb_pipe_stage_hs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // s1_*: SKID=1, FLUSH_KEEP=C0, RST_CTRL=00.  s0_*: SKID=0, FLUSH_KEEP=00, RST_CTRL=5A.
    logic        s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    logic [7:0]  s1_in_ctrl, s1_out_ctrl;
    logic [15:0] s1_in_data, s1_out_data;
    logic [1:0]  s1_occ;
    logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    logic [7:0]  s0_in_ctrl, s0_out_ctrl;
    logic [15:0] s0_in_data, s0_out_data;
    logic [1:0]  s0_occ;

    pipe_stage_hs #(.DATA_W(16), .CTRL_W(8), .RST_CTRL(8'h00), .FLUSH_KEEP(8'hC0), .SKID(1'b1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .flush(s1_flush), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .in_ctrl(s1_in_ctrl), .in_data(s1_in_data), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .out_ctrl(s1_out_ctrl), .out_data(s1_out_data), .occ(s1_occ)
    );

    pipe_stage_hs #(.DATA_W(16), .CTRL_W(8), .RST_CTRL(8'h5A), .FLUSH_KEEP(8'h00), .SKID(1'b0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .flush(s0_flush), .in_valid(s0_in_valid), .in_ready(s0_in_ready),
        .in_ctrl(s0_in_ctrl), .in_data(s0_in_data), .out_valid(s0_out_valid), .out_ready(s0_out_ready),
        .out_ctrl(s0_out_ctrl), .out_data(s0_out_data), .occ(s0_occ)
    );

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [7:0]  in_ctrl;
        logic [15:0] in_data;
        logic        out_ready;
        logic        e_valid;
        logic        e_ready;
        logic [1:0]  e_occ;
        logic        chk_pay;
        logic [7:0]  e_ctrl;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [23:0] q1[$];
    logic [23:0] q0[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic iv, input logic [7:0] ic, input logic [15:0] id,
                       input logic orr, input logic ev, input logic er, input logic [1:0] eo,
                       input logic cp, input logic [7:0] ec, input logic [15:0] ed);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.in_ctrl = ic; v.in_data = id; v.out_ready = orr;
        v.e_valid = ev; v.e_ready = er; v.e_occ = eo; v.chk_pay = cp; v.e_ctrl = ec; v.e_data = ed;
        vecs.push_back(v);
    endtask

    task automatic idle_s1();
        s1_flush = 0; s1_in_valid = 0; s1_in_ctrl = 0; s1_in_data = 0; s1_out_ready = 1;
    endtask

    task automatic idle_s0();
        s0_flush = 0; s0_in_valid = 0; s0_in_ctrl = 0; s0_in_data = 0; s0_out_ready = 1;
    endtask

    initial begin
        idle_s1();
        idle_s0();

        // Streaming, 1-cycle latency, occ stays 1
        for (int i = 0; i < 8; i++)
            add(0, 1, 8'(i), 16'h1000 + 16'(i), 1, 1, 1, 2'd1, 1, 8'(i), 16'h1000 + 16'(i));
        add(0, 0, 8'h00, 16'h0000, 1, 0, 1, 2'd0, 0, 8'h00, 16'h0000);
        // Stall 3 cycles while offering A, B, C
        add(0, 1, 8'hA1, 16'hA0A0, 0, 1, 1, 2'd1, 1, 8'hA1, 16'hA0A0);
        add(0, 1, 8'hB1, 16'hB0B0, 0, 1, 0, 2'd2, 1, 8'hA1, 16'hA0A0);
        add(0, 1, 8'hC1, 16'hC0C0, 0, 1, 0, 2'd2, 1, 8'hA1, 16'hA0A0);
        add(0, 1, 8'hC1, 16'hC0C0, 1, 1, 1, 2'd1, 1, 8'hB1, 16'hB0B0);
        add(0, 1, 8'hC1, 16'hC0C0, 1, 1, 1, 2'd1, 1, 8'hC1, 16'hC0C0);
        add(0, 0, 8'h00, 16'h0000, 1, 0, 1, 2'd0, 0, 8'h00, 16'h0000);
        // Flush from FULL with retained control bits
        add(0, 1, 8'h22, 16'h00D0, 0, 1, 1, 2'd1, 1, 8'h22, 16'h00D0);
        add(0, 1, 8'h33, 16'h00E0, 0, 1, 0, 2'd2, 1, 8'h22, 16'h00D0);
        add(1, 1, 8'hFF, 16'hFFFF, 0, 0, 1, 2'd0, 1, 8'hC0, 16'h0000);
        add(0, 0, 8'h00, 16'h0000, 1, 0, 1, 2'd0, 0, 8'h00, 16'h0000);
        // Flush with concurrent accept and emit: nothing replayed, accepted beat discarded
        add(0, 1, 8'h44, 16'hF0F0, 1, 1, 1, 2'd1, 1, 8'h44, 16'hF0F0);
        add(1, 1, 8'h0F, 16'h9999, 1, 0, 1, 2'd0, 1, 8'h00, 16'h0000);
        add(0, 0, 8'h00, 16'h0000, 1, 0, 1, 2'd0, 0, 8'h00, 16'h0000);
        add(0, 1, 8'h05, 16'h5555, 1, 1, 1, 2'd1, 1, 8'h05, 16'h5555);
        add(0, 0, 8'h00, 16'h0000, 1, 0, 1, 2'd0, 0, 8'h00, 16'h0000);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s1_valid", 32'(s1_out_valid), 32'd0);
        chk("rst_s1_ready", 32'(s1_in_ready), 32'd1);
        chk("rst_s1_occ", 32'(s1_occ), 32'd0);
        chk("rst_s1_ctrl", 32'(s1_out_ctrl), 32'h00);
        chk("rst_s1_data", 32'(s1_out_data), 32'd0);
        chk("rst_s0_valid", 32'(s0_out_valid), 32'd0);
        chk("rst_s0_ready", 32'(s0_in_ready), 32'd1);
        chk("rst_s0_occ", 32'(s0_occ), 32'd0);
        chk("rst_s0_ctrl", 32'(s0_out_ctrl), 32'h5A);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table on the skid build
        foreach (vecs[i]) begin
            @(negedge clk);
            s1_flush = vecs[i].flush; s1_in_valid = vecs[i].in_valid; s1_in_ctrl = vecs[i].in_ctrl;
            s1_in_data = vecs[i].in_data; s1_out_ready = vecs[i].out_ready;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(s1_out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_ready", i), 32'(s1_in_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_occ", i), 32'(s1_occ), 32'(vecs[i].e_occ));
            if (vecs[i].chk_pay) begin
                chk($sformatf("v%0d_ctrl", i), 32'(s1_out_ctrl), 32'(vecs[i].e_ctrl));
                chk($sformatf("v%0d_data", i), 32'(s1_out_data), 32'(vecs[i].e_data));
            end
        end
        @(negedge clk);
        idle_s1();

        // SKID=0: in_ready follows out_ready in the same cycle
        s0_in_valid = 1; s0_in_ctrl = 8'h07; s0_in_data = 16'h0077; s0_out_ready = 0;
        @(posedge clk);
        #1;
        chk("s0_load_valid", 32'(s0_out_valid), 32'd1);
        chk("s0_load_data", 32'(s0_out_data), 32'h0077);
        chk("s0_load_occ", 32'(s0_occ), 32'd1);
        s0_in_valid = 0;
        #1;
        chk("s0_bp_ready_low", 32'(s0_in_ready), 32'd0);
        s0_out_ready = 1;
        #1;
        chk("s0_bp_ready_high", 32'(s0_in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("s0_drain_valid", 32'(s0_out_valid), 32'd0);
        chk("s0_drain_occ", 32'(s0_occ), 32'd0);
        chk("s0_hold_data", 32'(s0_out_data), 32'h0077);
        @(negedge clk);
        s0_in_valid = 1; s0_in_ctrl = 8'h08; s0_in_data = 16'h0088; s0_out_ready = 0;
        @(negedge clk);
        s0_in_valid = 0; s0_flush = 1; s0_in_ctrl = 8'hFF;
        @(posedge clk);
        #1;
        chk("s0_flush_valid", 32'(s0_out_valid), 32'd0);
        chk("s0_flush_ctrl", 32'(s0_out_ctrl), 32'h5A);
        chk("s0_flush_data", 32'(s0_out_data), 32'd0);
        chk("s0_flush_ready", 32'(s0_in_ready), 32'd1);
        @(negedge clk);
        idle_s0();

        // SKID=1: in_ready is registered, independent of out_ready within a cycle
        s1_in_valid = 1; s1_in_data = 16'h0021; s1_out_ready = 0;
        @(posedge clk);
        #1;
        s1_in_valid = 0; s1_out_ready = 1;
        #1;
        chk("s1_one_ready_or1", 32'(s1_in_ready), 32'd1);
        s1_out_ready = 0; s1_in_valid = 1; s1_in_data = 16'h0022;
        #1;
        chk("s1_one_ready_or0", 32'(s1_in_ready), 32'd1);
        @(posedge clk);
        #1;
        s1_in_valid = 0;
        chk("s1_full_ready_or0", 32'(s1_in_ready), 32'd0);
        s1_out_ready = 1;
        #1;
        chk("s1_full_ready_or1", 32'(s1_in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("s1_refill_data", 32'(s1_out_data), 32'h0022);
        chk("s1_refill_ready", 32'(s1_in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("s1_drained", 32'(s1_out_valid), 32'd0);

        // Random traffic against reference FIFOs, both builds in parallel
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            s1_in_valid = ($urandom_range(0, 3) != 0); s1_out_ready = 1'($urandom_range(0, 1));
            s1_in_ctrl = 8'($urandom); s1_in_data = 16'($urandom);
            s0_in_valid = ($urandom_range(0, 3) != 0); s0_out_ready = 1'($urandom_range(0, 1));
            s0_in_ctrl = 8'($urandom); s0_in_data = 16'($urandom);
            #1;
            chk("rnd_s1_valid", 32'(s1_out_valid), 32'(q1.size() != 0));
            chk("rnd_s1_occ", 32'(s1_occ), 32'(q1.size()));
            chk("rnd_s1_ready", 32'(s1_in_ready), 32'(q1.size() < 2));
            chk("rnd_s0_valid", 32'(s0_out_valid), 32'(q0.size() != 0));
            chk("rnd_s0_occ", 32'(s0_occ), 32'(q0.size()));
            chk("rnd_s0_ready", 32'(s0_in_ready), 32'(s0_out_ready || q0.size() == 0));
            if (s1_out_valid && s1_out_ready && q1.size() != 0) begin
                chk("rnd_s1_order", 32'({s1_out_ctrl, s1_out_data}), 32'(q1[0]));
                void'(q1.pop_front());
            end
            if (s1_in_valid && s1_in_ready) q1.push_back({s1_in_ctrl, s1_in_data});
            if (s0_out_valid && s0_out_ready && q0.size() != 0) begin
                chk("rnd_s0_order", 32'({s0_out_ctrl, s0_out_data}), 32'(q0[0]));
                void'(q0.pop_front());
            end
            if (s0_in_valid && s0_in_ready) q0.push_back({s0_in_ctrl, s0_in_data});
        end
        @(negedge clk);
        idle_s1();
        idle_s0();
        repeat (3) @(negedge clk);

        // Asynchronous reset while holding two beats
        s1_in_valid = 1; s1_in_data = 16'h0031; s1_in_ctrl = 8'h31; s1_out_ready = 0;
        @(negedge clk);
        s1_in_data = 16'h0032; s1_in_ctrl = 8'h32;
        @(posedge clk);
        #1;
        chk("areset_pre_occ", 32'(s1_occ), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", 32'(s1_out_valid), 32'd0);
        chk("areset_occ", 32'(s1_occ), 32'd0);
        chk("areset_data", 32'(s1_out_data), 32'd0);
        chk("areset_ready", 32'(s1_in_ready), 32'd1);
        chk("areset_ctrl", 32'(s1_out_ctrl), 32'h00);
        idle_s1();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
